// File: rtl/decode_byte_queue.sv
// Instruction byte queue between fetch and decode: circular byte buffer filled in
// fixed-size chunks, presenting the oldest WIN_BYTES bytes as a masked window.
module decode_byte_queue #(
  parameter int DEPTH     = 32,
  parameter int IN_BYTES  = 16,
  parameter int WIN_BYTES = 16,
  parameter int PTR_W     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic [8*IN_BYTES-1:0]    fetch_data,
  output logic                     fetch_ready,
  output logic [8*WIN_BYTES-1:0]   win_data,
  output logic [PTR_W:0]           win_count,
  input  logic                     consume_en,
  input  logic [3:0]               consume_len,
  output logic [PTR_W:0]           occupancy,
  output logic                     overrun_err
);

  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             wr_fire;
  logic             rd_fire;
  logic             rd_bad;

  function automatic logic [CNT_W-1:0] sat_win(input logic [CNT_W-1:0] c);
    if (c > CNT_W'(WIN_BYTES)) return CNT_W'(WIN_BYTES);
    return c;
  endfunction

  // Space check uses registered count only; a same-cycle consume earns no credit.
  assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(IN_BYTES);
  assign win_count   = sat_win(count);
  assign occupancy   = count;

  assign rd_bad  = consume_en && (CNT_W'(consume_len) > win_count);
  assign wr_fire = fetch_valid && fetch_ready && !flush;
  assign rd_fire = consume_en && !flush && !rd_bad;

  always_comb begin
    count_next = count;
    if (wr_fire) count_next = count_next + CNT_W'(IN_BYTES);
    if (rd_fire) count_next = count_next - CNT_W'(consume_len);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overrun_err <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(IN_BYTES);
        if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(consume_len);
        count <= count_next;
      end
      if (rd_bad) overrun_err <= 1'b1;
    end
  end

  // Byte storage carries no reset; bytes past count are masked off the window.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < IN_BYTES; k++) begin
        mem[wr_ptr + PTR_W'(k)] <= fetch_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < WIN_BYTES; k++) begin
      if (CNT_W'(k) < count) win_data[8*k +: 8] = mem[rd_ptr + PTR_W'(k)];
    end
  end

endmodule

// File: tb/tb_decode_byte_queue.sv
// Directed bench for decode_byte_queue: fill, consume, full, wrap, same-cycle and flush cases.
module tb_decode_byte_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         fetch_valid;
  logic [127:0] fetch_data;
  logic         fetch_ready;
  logic [127:0] win_data;
  logic [5:0]   win_count;
  logic         consume_en;
  logic [3:0]   consume_len;
  logic [5:0]   occupancy;
  logic         overrun_err;

  int n_tests = 0;
  int n_fail  = 0;

  decode_byte_queue dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_ready (fetch_ready),
    .win_data    (win_data),
    .win_count   (win_count),
    .consume_en  (consume_en),
    .consume_len (consume_len),
    .occupancy   (occupancy),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_chunk(input logic [7:0] base);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  function automatic logic [7:0] wbyte(input int k);
    return win_data[8*k +: 8];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; consume_en = 1'b0; consume_len = 4'd0;
  endtask

  task automatic push(input logic [127:0] d);
    fetch_valid = 1'b1; fetch_data = d; step();
  endtask

  task automatic take(input int n);
    consume_en = 1'b1; consume_len = 4'(n); step();
  endtask

  task automatic do_flush();
    flush = 1'b1; step();
  endtask

  logic [127:0] exp_win;
  logic [127:0] chunk;

  initial begin
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
    consume_en = 1'b0; consume_len = 4'd0;
    @(posedge clk); #1;
    reset = 1'b1; step();

    check_eq("rst_ready", 128'(fetch_ready), 128'd1);
    check_eq("rst_wcount", 128'(win_count), 128'd0);
    check_eq("rst_wdata", win_data, 128'd0);
    check_eq("rst_occ", 128'(occupancy), 128'd0);
    check_eq("rst_ovr", 128'(overrun_err), 128'd0);

    // 1: first chunk
    push(mk_chunk(8'h00));
    check_eq("t1_wcount", 128'(win_count), 128'd16);
    check_eq("t1_b0", 128'(wbyte(0)), 128'h00);
    check_eq("t1_b15", 128'(wbyte(15)), 128'h0F);
    check_eq("t1_occ", 128'(occupancy), 128'd16);
    take(0);
    check_eq("t1_len0_occ", 128'(occupancy), 128'd16);
    check_eq("t1_len0_ovr", 128'(overrun_err), 128'd0);

    // 2: prefix bytes retired
    do_flush();
    chunk = mk_chunk(8'h10);
    chunk[7:0] = 8'h66; chunk[15:8] = 8'hF3; chunk[23:16] = 8'h0F;
    push(chunk);
    check_eq("t2_b0_pre", 128'(wbyte(0)), 128'h66);
    take(2);
    check_eq("t2_b0", 128'(wbyte(0)), 128'h0F);
    check_eq("t2_b1", 128'(wbyte(1)), 128'h13);
    check_eq("t2_occ", 128'(occupancy), 128'd14);
    check_eq("t2_wcount", 128'(win_count), 128'd14);
    check_eq("t2_b15_mask", 128'(wbyte(15)), 128'h00);

    // 3: full queue ignores fetch_valid
    do_flush();
    push(mk_chunk(8'h20));
    push(mk_chunk(8'h30));
    check_eq("t3_ready_full", 128'(fetch_ready), 128'd0);
    check_eq("t3_occ_full", 128'(occupancy), 128'd32);
    push(mk_chunk(8'h40));
    check_eq("t3_occ_nowr", 128'(occupancy), 128'd32);
    check_eq("t3_b0_nowr", 128'(wbyte(0)), 128'h20);
    take(15);
    take(1);
    check_eq("t3_ready", 128'(fetch_ready), 128'd1);
    check_eq("t3_occ", 128'(occupancy), 128'd16);
    check_eq("t3_b0", 128'(wbyte(0)), 128'h30);

    // 4: window straddles the buffer end
    do_flush();
    push(mk_chunk(8'h20));
    push(mk_chunk(8'h30));
    take(15);
    take(13);
    push(mk_chunk(8'hA0));
    for (int k = 0; k < 4; k++)  exp_win[8*k +: 8] = 8'h3C + 8'(k);
    for (int k = 4; k < 16; k++) exp_win[8*k +: 8] = 8'hA0 + 8'(k - 4);
    check_eq("t4_win", win_data, exp_win);
    check_eq("t4_wcount", 128'(win_count), 128'd16);
    check_eq("t4_occ", 128'(occupancy), 128'd20);

    // 5: write and consume in the same cycle
    take(4);
    check_eq("t5_occ16", 128'(occupancy), 128'd16);
    check_eq("t5_b0_pre", 128'(wbyte(0)), 128'hA0);
    fetch_valid = 1'b1; fetch_data = mk_chunk(8'hB0);
    consume_en = 1'b1; consume_len = 4'd5;
    step();
    check_eq("t5_occ", 128'(occupancy), 128'd27);
    check_eq("t5_b0", 128'(wbyte(0)), 128'hA5);
    check_eq("t5_b11", 128'(wbyte(11)), 128'hB0);

    // 6: flush beats pending write and consume, then empty over-consume
    flush = 1'b1; fetch_valid = 1'b1; fetch_data = mk_chunk(8'hE0);
    consume_en = 1'b1; consume_len = 4'd2;
    step();
    check_eq("t6_occ", 128'(occupancy), 128'd0);
    check_eq("t6_wdata", win_data, 128'd0);
    check_eq("t6_ovr0", 128'(overrun_err), 128'd0);
    check_eq("t6_ready", 128'(fetch_ready), 128'd1);
    take(3);
    check_eq("t6_ovr1", 128'(overrun_err), 128'd1);
    check_eq("t6_occ_bad", 128'(occupancy), 128'd0);
    push(mk_chunk(8'hC0));
    check_eq("t6_b0_rdptr", 128'(wbyte(0)), 128'hC0);
    take(15);
    check_eq("t6_occ_after15", 128'(occupancy), 128'd1);
    take(2);
    check_eq("t6_occ_bad2", 128'(occupancy), 128'd1);
    check_eq("t6_b0_bad2", 128'(wbyte(0)), 128'hCF);
    do_flush();
    check_eq("t6_ovr_sticky", 128'(overrun_err), 128'd1);
    reset = 1'b1; fetch_valid = 1'b1; fetch_data = mk_chunk(8'h50);
    step();
    check_eq("rst2_ovr", 128'(overrun_err), 128'd0);
    check_eq("rst2_occ", 128'(occupancy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
